sram_packet_reader: RTL and testbench



---
 rtl/sram_packet_reader.sv | 221 ++++++++++++++++++++++
 tb/tb_sram_packet_reader.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_packet_reader.sv
// Read engine for one output port: follows a packet's page chain across SRAMs,
// SEC-corrects every 8-halfword page and streams the corrected halfwords out.
module sram_packet_reader #(
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    input  logic [3:0]           req_sram,
    input  logic [7:0]           req_head,
    output logic                 req_ready,
    output logic                 rd_page_down,
    output logic [3:0]           rd_sram_sel,
    output logic [7:0]           rd_page,
    input  logic [15:0]          rd_xfer_data,
    input  logic [11:0]          rd_next_page,
    input  logic [7:0]           rd_ecc_code,
    output logic                 out_vld,
    output logic [15:0]          out_data,
    output logic                 out_eop,
    output logic                 ecc_corr_pulse,
    output logic [ERR_CNT_W-1:0] ecc_err_cnt
);

    typedef enum logic [1:0] {IDLE, FETCH, CHECK, DRAIN} state_t;

    // Hamming position of data bit idx: data occupies the non-power-of-two positions 3..136
    function automatic logic [7:0] data_pos(input int idx);
        logic [7:0] pos;
        int         n;
        pos = 8'd0;
        n   = 0;
        for (int p = 3; p <= 136; p++) begin
            if ((p & (p - 1)) != 0) begin
                if (n == idx) pos = 8'(p);
                n++;
            end
        end
        return pos;
    endfunction

    state_t      state;
    logic [3:0]  beat;
    logic [15:0] cap [8];
    logic [11:0] next_ptr;
    logic [7:0]  stored_ecc;
    logic        first_page;
    logic [5:0]  page_idx;
    logic [5:0]  total_pages;
    logic [2:0]  last_n;
    logic        page_down_q;

    logic [15:0] obuf [8];
    logic [2:0]  emit_idx;
    logic [3:0]  emit_rem;
    logic        emit_last;

    logic [7:0]   pos_tbl [128];
    logic [127:0] flat;
    logic [127:0] corr_flat;
    logic [7:0]   calc_ecc;
    logic [7:0]   syn;
    logic         pre_last;
    logic         post_last;
    logic [2:0]   pre_n;
    logic [2:0]   post_n;
    logic         data_hit;
    logic         parity_hit;
    logic [15:0]  corr_words [8];
    logic [3:0]   n_words;

    for (genvar g = 0; g < 128; g++) begin : g_pos
        localparam logic [7:0] POS = data_pos(g);
        assign pos_tbl[g] = POS;
    end

    // The first page's zero-fill must be decided before correction, so it uses the raw header
    always_comb begin
        pre_last = first_page ? (cap[0][11:7] == 5'd0) : (page_idx + 6'd1 == total_pages);
        pre_n    = first_page ? cap[0][6:4] : last_n;
        flat     = '0;
        for (int j = 0; j < 8; j++) begin
            flat[16*j +: 16] = (pre_last && j > int'(pre_n)) ? 16'h0000 : cap[j];
        end

        calc_ecc = '0;
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < 128; i++) begin
                calc_ecc[k] = calc_ecc[k] ^ (flat[i] & pos_tbl[i][k]);
            end
        end
        syn = calc_ecc ^ stored_ecc;

        corr_flat = flat;
        data_hit  = 1'b0;
        for (int i = 0; i < 128; i++) begin
            if (syn != 8'd0 && pos_tbl[i] == syn) begin
                corr_flat[i] = ~flat[i];
                data_hit     = 1'b1;
            end
        end
        parity_hit = (syn != 8'd0) && ((syn & (syn - 8'd1)) == 8'd0);

        for (int j = 0; j < 8; j++) begin
            corr_words[j] = corr_flat[16*j +: 16];
        end

        post_last = first_page ? (corr_words[0][11:7] == 5'd0) : pre_last;
        post_n    = first_page ? corr_words[0][6:4] : last_n;
        n_words   = post_last ? ({1'b0, post_n} + 4'd1) : 4'd8;
    end

    // The chained page-open must land in the CHECK cycle itself, once the page count is known
    assign rd_page_down = page_down_q | ((state == CHECK) && !post_last);

    // Fetch/check sequencing, output buffer drain and error accounting
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= IDLE;
            beat           <= '0;
            next_ptr       <= '0;
            stored_ecc     <= '0;
            first_page     <= 1'b0;
            page_idx       <= '0;
            total_pages    <= '0;
            last_n         <= '0;
            page_down_q    <= 1'b0;
            emit_idx       <= '0;
            emit_rem       <= '0;
            emit_last      <= 1'b0;
            req_ready      <= 1'b1;
            rd_sram_sel    <= '0;
            rd_page        <= '0;
            out_vld        <= 1'b0;
            out_data       <= '0;
            out_eop        <= 1'b0;
            ecc_corr_pulse <= 1'b0;
            ecc_err_cnt    <= '0;
            for (int j = 0; j < 8; j++) begin
                cap[j]  <= '0;
                obuf[j] <= '0;
            end
        end else begin
            page_down_q    <= 1'b0;
            ecc_corr_pulse <= 1'b0;

            if (emit_rem != 4'd0) begin
                out_vld  <= 1'b1;
                out_data <= obuf[emit_idx];
                out_eop  <= emit_last && (emit_rem == 4'd1);
                emit_idx <= emit_idx + 3'd1;
                emit_rem <= emit_rem - 4'd1;
            end else begin
                out_vld <= 1'b0;
                out_eop <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (req_valid) begin
                        req_ready   <= 1'b0;
                        rd_sram_sel <= req_sram;
                        rd_page     <= req_head;
                        page_down_q <= 1'b1;
                        beat        <= 4'd0;
                        first_page  <= 1'b1;
                        page_idx    <= '0;
                        state       <= FETCH;
                    end
                end
                FETCH: begin
                    if (beat != 4'd0) cap[3'(beat - 4'd1)] <= rd_xfer_data;
                    if (beat == 4'd1) begin
                        next_ptr   <= rd_next_page;
                        stored_ecc <= rd_ecc_code;
                    end
                    if (beat == 4'd8) begin
                        rd_sram_sel <= next_ptr[11:8];
                        rd_page     <= next_ptr[7:0];
                        state       <= CHECK;
                    end else begin
                        beat <= beat + 4'd1;
                    end
                end
                CHECK: begin
                    obuf      <= corr_words;
                    out_vld   <= 1'b1;
                    out_data  <= corr_words[0];
                    out_eop   <= post_last && (n_words == 4'd1);
                    emit_idx  <= 3'd1;
                    emit_rem  <= n_words - 4'd1;
                    emit_last <= post_last;
                    if (data_hit || parity_hit) begin
                        ecc_corr_pulse <= 1'b1;
                        if (ecc_err_cnt != '1) ecc_err_cnt <= ecc_err_cnt + ERR_CNT_W'(1);
                    end
                    if (first_page) begin
                        total_pages <= {1'b0, corr_words[0][11:7]} + 6'd1;
                        last_n      <= corr_words[0][6:4];
                        first_page  <= 1'b0;
                    end
                    page_idx <= page_idx + 6'd1;
                    if (post_last) begin
                        state <= DRAIN;
                    end else begin
                        beat  <= 4'd1;
                        state <= FETCH;
                    end
                end
                DRAIN: begin
                    if (emit_rem == 4'd0) begin
                        req_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_packet_reader.sv
// Self-checking bench for sram_packet_reader: SRAM responder, monitor and a
// packet-level reference model built from the header/page/Hamming rules.
module tb_sram_packet_reader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic [3:0]  req_sram = '0;
    logic [7:0]  req_head = '0;
    logic        req_ready;
    logic        rd_page_down;
    logic [3:0]  rd_sram_sel;
    logic [7:0]  rd_page;
    logic [15:0] rd_xfer_data = '0;
    logic [11:0] rd_next_page = '0;
    logic [7:0]  rd_ecc_code = '0;
    logic        out_vld;
    logic [15:0] out_data;
    logic        out_eop;
    logic        ecc_corr_pulse;
    logic [7:0]  ecc_err_cnt;

    sram_packet_reader #(.ERR_CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_sram(req_sram), .req_head(req_head), .req_ready(req_ready),
        .rd_page_down(rd_page_down), .rd_sram_sel(rd_sram_sel), .rd_page(rd_page),
        .rd_xfer_data(rd_xfer_data), .rd_next_page(rd_next_page), .rd_ecc_code(rd_ecc_code),
        .out_vld(out_vld), .out_data(out_data), .out_eop(out_eop),
        .ecc_corr_pulse(ecc_corr_pulse), .ecc_err_cnt(ecc_err_cnt)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int c; logic [3:0] s; logic [7:0] p; } down_t;
    typedef struct { int c; logic [15:0] d; logic e; } out_t;

    logic [15:0] mem  [16][256][8];
    logic [11:0] nxt  [16][256];
    logic [7:0]  eccm [16][256];

    down_t       down_q [$];
    out_t        out_q [$];
    int          pulse_q [$];

    logic [3:0]  ch_s [$];
    logic [7:0]  ch_p [$];
    logic [15:0] exp_words [$];
    int          err_pages [$];
    int          cur_len;
    int          exp_err_total = 0;

    // SRAM responder: halfwords in T+1..T+8, pointer and code only in T+1
    int          beat = 9;
    logic [3:0]  rs;
    logic [7:0]  rp;
    always @(negedge clk) begin
        if (rd_page_down) begin
            rs   = rd_sram_sel;
            rp   = rd_page;
            beat = 0;
        end else if (beat < 9) begin
            beat = beat + 1;
        end
        if (beat >= 1 && beat <= 8) rd_xfer_data = mem[rs][rp][beat-1];
        else rd_xfer_data = 16'($urandom);
        if (beat == 1) begin
            rd_next_page = nxt[rs][rp];
            rd_ecc_code  = eccm[rs][rp];
        end else begin
            rd_next_page = 12'($urandom);
            rd_ecc_code  = 8'($urandom);
        end
    end

    always @(negedge clk) begin
        if (rd_page_down) down_q.push_back('{cyc, rd_sram_sel, rd_page});
        if (out_vld) out_q.push_back('{cyc, out_data, out_eop});
        if (ecc_corr_pulse) pulse_q.push_back(cyc);
    end

    // Reference encoder: syndrome is the XOR of Hamming positions of all set data bits
    function automatic logic [7:0] ham(input logic [127:0] f);
        logic [7:0] s;
        int idx;
        s = 8'd0;
        idx = 0;
        for (int p = 1; p <= 136; p++) begin
            if ((p & (p - 1)) != 0) begin
                if (f[idx]) s = s ^ 8'(p);
                idx++;
            end
        end
        return s;
    endfunction

    task automatic make_chain(input int np);
        int off;
        ch_s.delete();
        ch_p.delete();
        off = $urandom_range(0, 255);
        for (int k = 0; k < np; k++) begin
            ch_s.push_back(4'($urandom));
            ch_p.push_back(8'((off + k) % 256));
        end
    endtask

    // emode: 0 clean, 1 data flip at (epage,ehw,ebit), 2 code flip at epage bit ebit, 3 data flip every page
    task automatic build_packet(input int len, input int emode, input int epage, input int ehw, input int ebit);
        int np, nv, j, b;
        logic [127:0] f;
        logic [15:0] w;
        np = (len + 7) / 8;
        cur_len = len;
        exp_words.delete();
        err_pages.delete();
        for (int i = 0; i < len; i++) begin
            w = 16'($urandom);
            if (i == 0) w[11:4] = 8'(len - 1);
            exp_words.push_back(w);
        end
        for (int k = 0; k < np; k++) begin
            for (int jj = 0; jj < 8; jj++) begin
                if (8*k + jj < len) begin
                    f[16*jj +: 16] = exp_words[8*k + jj];
                    mem[ch_s[k]][ch_p[k]][jj] = exp_words[8*k + jj];
                end else begin
                    f[16*jj +: 16] = 16'h0000;
                    mem[ch_s[k]][ch_p[k]][jj] = 16'($urandom) | 16'h0001;
                end
            end
            eccm[ch_s[k]][ch_p[k]] = ham(f);
            nxt[ch_s[k]][ch_p[k]] = (k < np - 1) ? {ch_s[k+1], ch_p[k+1]} : 12'($urandom);
            nv = (k == np - 1) ? len - 8*k : 8;
            if ((emode == 1 && k == epage) || emode == 3) begin
                if (emode == 1) j = ehw;
                else if (k == 0) j = (nv > 1) ? $urandom_range(1, nv - 1) : -1;
                else j = $urandom_range(0, nv - 1);
                b = (emode == 1) ? ebit : $urandom_range(0, 15);
                if (j >= 0) begin
                    mem[ch_s[k]][ch_p[k]][j] = mem[ch_s[k]][ch_p[k]][j] ^ (16'd1 << b);
                    err_pages.push_back(k);
                end
            end
            if (emode == 2 && k == epage) begin
                eccm[ch_s[k]][ch_p[k]] = eccm[ch_s[k]][ch_p[k]] ^ (8'd1 << ebit);
                err_pages.push_back(k);
            end
        end
    endtask

    task automatic run_and_check(input string name);
        int a, np, last_out, t, n;
        down_q.delete();
        out_q.delete();
        pulse_q.delete();
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL %s ready_before: got %0b expected 1", name, req_ready);
        end
        req_valid = 1'b1;
        req_sram  = ch_s[0];
        req_head  = ch_p[0];
        a = cyc;
        @(negedge clk);
        req_valid = 1'b0;
        np = (cur_len + 7) / 8;
        last_out = a + 11 + 9*(np - 1) + (cur_len - 8*(np - 1)) - 1;
        t = 0;
        while (req_ready !== 1'b1 && t < 400) begin
            req_valid = 1'($urandom);
            req_sram  = 4'($urandom);
            req_head  = 8'($urandom);
            @(negedge clk);
            t++;
        end
        req_valid = 1'b0;
        checks++;
        if (cyc != last_out + 1) begin
            errors++;
            $display("[TB] FAIL %s ready_cycle: got %0d expected %0d", name, cyc - a, last_out + 1 - a);
        end
        repeat (2) @(negedge clk);

        checks++;
        if (down_q.size() != np) begin
            errors++;
            $display("[TB] FAIL %s down_count: got %0d expected %0d", name, down_q.size(), np);
        end
        n = (down_q.size() < np) ? down_q.size() : np;
        for (int k = 0; k < n; k++) begin
            checks++;
            if (down_q[k].c != a + 1 + 9*k || down_q[k].s !== ch_s[k] || down_q[k].p !== ch_p[k]) begin
                errors++;
                $display("[TB] FAIL %s down[%0d]: got cyc+%0d sel %0h page %0h expected cyc+%0d sel %0h page %0h",
                         name, k, down_q[k].c - a, down_q[k].s, down_q[k].p, 1 + 9*k, ch_s[k], ch_p[k]);
            end
        end

        checks++;
        if (out_q.size() != cur_len) begin
            errors++;
            $display("[TB] FAIL %s out_count: got %0d expected %0d", name, out_q.size(), cur_len);
        end
        n = (out_q.size() < cur_len) ? out_q.size() : cur_len;
        for (int i = 0; i < n; i++) begin
            checks++;
            if (out_q[i].d !== exp_words[i] || out_q[i].e !== (i == cur_len - 1) ||
                out_q[i].c != a + 11 + 9*(i/8) + (i%8)) begin
                errors++;
                $display("[TB] FAIL %s out[%0d]: got %0h eop %0b cyc+%0d expected %0h eop %0b cyc+%0d",
                         name, i, out_q[i].d, out_q[i].e, out_q[i].c - a, exp_words[i],
                         (i == cur_len - 1), 11 + 9*(i/8) + (i%8));
            end
        end

        checks++;
        if (pulse_q.size() != err_pages.size()) begin
            errors++;
            $display("[TB] FAIL %s pulse_count: got %0d expected %0d", name, pulse_q.size(), err_pages.size());
        end else begin
            for (int k = 0; k < pulse_q.size(); k++) begin
                checks++;
                if (pulse_q[k] != a + 11 + 9*err_pages[k]) begin
                    errors++;
                    $display("[TB] FAIL %s pulse[%0d]: got cyc+%0d expected cyc+%0d",
                             name, k, pulse_q[k] - a, 11 + 9*err_pages[k]);
                end
            end
        end

        exp_err_total += err_pages.size();
        checks++;
        if (ecc_err_cnt !== 8'((exp_err_total > 255) ? 255 : exp_err_total)) begin
            errors++;
            $display("[TB] FAIL %s err_cnt: got %0d expected %0d", name, ecc_err_cnt,
                     (exp_err_total > 255) ? 255 : exp_err_total);
        end
    endtask

    task automatic test_reset();
        logic [40:0] rv, rexp;
        repeat (3) @(negedge clk);
        rv = {req_ready, rd_page_down, rd_sram_sel, rd_page, out_vld, out_data, out_eop, ecc_corr_pulse, ecc_err_cnt};
        rexp = '0;
        rexp[40] = 1'b1;
        checks++;
        if (rv !== rexp) begin
            errors++;
            $display("[TB] FAIL reset_values: got %0h expected %0h", rv, rexp);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_single_page();
        ch_s = '{4'd2};
        ch_p = '{8'h10};
        build_packet(4, 0, 0, 0, 0);
        run_and_check("single_page");
    endtask

    task automatic test_three_page();
        ch_s = '{4'd0, 4'd3, 4'd3};
        ch_p = '{8'h05, 8'h40, 8'h41};
        build_packet(20, 0, 0, 0, 0);
        run_and_check("three_page");
    endtask

    task automatic test_data_flip();
        ch_s = '{4'd0, 4'd3, 4'd3};
        ch_p = '{8'h05, 8'h40, 8'h41};
        build_packet(20, 1, 1, 5, 9);
        run_and_check("data_flip");
    endtask

    task automatic test_parity_flip();
        make_chain(3);
        build_packet(24, 2, 2, 0, 3);
        run_and_check("parity_flip");
    endtask

    task automatic test_stale_last();
        make_chain(2);
        build_packet(10, 0, 0, 0, 0);
        run_and_check("stale_last");
    endtask

    task automatic test_random();
        int len, np, mode, ep, nv, hw;
        for (int r = 0; r < 6; r++) begin
            len  = (r == 0) ? 256 : ((r == 1) ? 1 : $urandom_range(1, 256));
            np   = (len + 7) / 8;
            mode = $urandom_range(0, 2);
            ep   = $urandom_range(0, np - 1);
            nv   = (ep == np - 1) ? len - 8*ep : 8;
            if (mode == 1 && ep == 0 && nv == 1) mode = 0;
            hw   = (ep == 0) ? ((nv > 1) ? $urandom_range(1, nv - 1) : 0) : $urandom_range(0, nv - 1);
            make_chain(np);
            build_packet(len, mode, ep, hw, (mode == 2) ? $urandom_range(0, 7) : $urandom_range(0, 15));
            run_and_check("random");
        end
    endtask

    task automatic test_saturate();
        for (int r = 0; r < 8; r++) begin
            make_chain(32);
            build_packet(256, 3, 0, 0, 0);
            run_and_check("saturate");
        end
    endtask

    task automatic test_reset_midpacket();
        int a;
        logic [40:0] rv, rexp;
        make_chain(3);
        build_packet(20, 0, 0, 0, 0);
        @(negedge clk);
        req_valid = 1'b1;
        req_sram  = ch_s[0];
        req_head  = ch_p[0];
        a = cyc;
        @(negedge clk);
        req_valid = 1'b0;
        while (cyc < a + 13) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rv = {req_ready, rd_page_down, rd_sram_sel, rd_page, out_vld, out_data, out_eop, ecc_corr_pulse, ecc_err_cnt};
        rexp = '0;
        rexp[40] = 1'b1;
        checks++;
        if (rv !== rexp) begin
            errors++;
            $display("[TB] FAIL midreset_values: got %0h expected %0h", rv, rexp);
        end
        exp_err_total = 0;
        rst_n = 1'b1;
        down_q.delete();
        out_q.delete();
        repeat (30) @(negedge clk);
        checks++;
        if (down_q.size() != 0 || out_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL midreset_quiet: got downs %0d outs %0d expected 0 0", down_q.size(), out_q.size());
        end
        make_chain(2);
        build_packet(13, 1, 1, 2, 4);
        run_and_check("after_reset");
    endtask

    initial begin
        test_reset();
        test_single_page();
        test_three_page();
        test_data_flip();
        test_parity_flip();
        test_stale_last();
        test_random();
        test_saturate();
        test_reset_midpacket();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
